// File: rtl/branch_predictor.sv
// +--------------------------------------------------------------------------+
// | branch_predictor: direct-mapped BTB with saturating direction counters.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_BITS  = 2,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  // IF-stage lookup
  input  logic [XLEN-1:0]      pred_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_next_pc,
  // Ex-stage resolution
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic                 upd_is_cf,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken,
  input  logic [XLEN-1:0]      upd_target,
  input  logic                 upd_pred_taken,
  input  logic [XLEN-1:0]      upd_pred_target,
  output logic                 upd_mispredict,
  output logic [XLEN-1:0]      upd_redirect_pc,
  output logic [PERF_BITS-1:0] perf_cf_count,
  output logic [PERF_BITS-1:0] perf_mispredict_count
);

  localparam int IDX     = $clog2(ENTRIES);
  localparam int TAG_W   = XLEN - IDX - 2;

  localparam logic [CNT_BITS-1:0]  c_weak_t   = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0]  c_cnt_max  = '1;
  localparam logic [PERF_BITS-1:0] c_perf_max = '1;
  localparam logic [XLEN-1:0]      c_four     = XLEN'(4);

  logic                r_valid   [ENTRIES];
  logic [TAG_W-1:0]    r_tag     [ENTRIES];
  logic [XLEN-1:0]     r_target  [ENTRIES];
  logic                r_is_jump [ENTRIES];
  logic [CNT_BITS-1:0] r_cnt     [ENTRIES];

  logic [PERF_BITS-1:0] r_perf_cf;
  logic [PERF_BITS-1:0] r_perf_mis;

  logic [IDX-1:0]   w_pidx;
  logic [TAG_W-1:0] w_ptag;
  logic [IDX-1:0]   w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic             w_actual;
  logic             w_mispredict;
  logic             w_unused_pc_lsbs;

  // Word-aligned fetch: the low two PC bits never select or tag an entry.
  assign w_unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

  assign w_pidx = pred_pc[IDX+1:2];
  assign w_ptag = pred_pc[XLEN-1:IDX+2];
  assign w_uidx = upd_pc[IDX+1:2];
  assign w_utag = upd_pc[XLEN-1:IDX+2];

  // Lookup reads only registered state, so a same-cycle update is not visible.
  assign pred_hit     = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
  assign pred_taken   = pred_hit && (r_is_jump[w_pidx] || r_cnt[w_pidx][CNT_BITS-1]);
  assign pred_next_pc = pred_taken ? r_target[w_pidx] : (pred_pc + c_four);

  assign w_uhit       = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_actual     = upd_is_cf && upd_taken;
  assign w_mispredict = upd_valid &&
                        ((w_actual != upd_pred_taken) ||
                         (w_actual && (upd_pred_target != upd_target)));

  assign upd_mispredict  = w_mispredict;
  assign upd_redirect_pc = w_actual ? upd_target : (upd_pc + c_four);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]   <= 1'b0;
        r_tag[i]     <= '0;
        r_target[i]  <= '0;
        r_is_jump[i] <= 1'b0;
        r_cnt[i]     <= '0;
      end
    end else if (upd_valid) begin
      if (upd_is_cf) begin
        if (w_uhit) begin
          if (upd_taken) begin
            if (r_cnt[w_uidx] != c_cnt_max) begin
              r_cnt[w_uidx] <= r_cnt[w_uidx] + CNT_BITS'(1);
            end
            r_target[w_uidx] <= upd_target;
          end else if (r_cnt[w_uidx] != '0) begin
            r_cnt[w_uidx] <= r_cnt[w_uidx] - CNT_BITS'(1);
          end
          r_is_jump[w_uidx] <= upd_is_jump;
        end else if (upd_taken) begin
          // Allocation evicts whatever occupied the slot.
          r_valid[w_uidx]   <= 1'b1;
          r_tag[w_uidx]     <= w_utag;
          r_target[w_uidx]  <= upd_target;
          r_is_jump[w_uidx] <= upd_is_jump;
          r_cnt[w_uidx]     <= c_weak_t;
        end
      end else if (w_uhit) begin
        // A non-branch matching an entry means the entry is stale or aliased.
        r_valid[w_uidx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cf  <= '0;
      r_perf_mis <= '0;
    end else begin
      if (upd_valid && upd_is_cf && (r_perf_cf != c_perf_max)) begin
        r_perf_cf <= r_perf_cf + PERF_BITS'(1);
      end
      if (w_mispredict && (r_perf_mis != c_perf_max)) begin
        r_perf_mis <= r_perf_mis + PERF_BITS'(1);
      end
    end
  end

  assign perf_cf_count         = r_perf_cf;
  assign perf_mispredict_count = r_perf_mis;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// Vector-table bench for branch_predictor; expected records flow through a scoreboard queue.
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cf;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        upd_mispredict;
  logic [31:0] upd_redirect_pc;
  logic [31:0] perf_cf_count;
  logic [31:0] perf_mispredict_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .XLEN(32), .ENTRIES(16), .CNT_BITS(2), .PERF_BITS(32)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .pred_pc               (pred_pc),
    .pred_hit              (pred_hit),
    .pred_taken            (pred_taken),
    .pred_next_pc          (pred_next_pc),
    .upd_valid             (upd_valid),
    .upd_pc                (upd_pc),
    .upd_is_cf             (upd_is_cf),
    .upd_is_jump           (upd_is_jump),
    .upd_taken             (upd_taken),
    .upd_target            (upd_target),
    .upd_pred_taken        (upd_pred_taken),
    .upd_pred_target       (upd_pred_target),
    .upd_mispredict        (upd_mispredict),
    .upd_redirect_pc       (upd_redirect_pc),
    .perf_cf_count         (perf_cf_count),
    .perf_mispredict_count (perf_mispredict_count)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        cf;
    logic        jmp;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_hit;
    logic        e_tk;
    logic [31:0] e_next;
    logic        e_mis;
    logic [31:0] e_redir;
    logic [31:0] e_pcf;
    logic [31:0] e_pmis;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(
    input logic r, input logic [31:0] pc,
    input logic uv, input logic [31:0] upc, input logic cf, input logic jmp,
    input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
    input logic e_hit, input logic e_tk, input logic [31:0] e_next,
    input logic e_mis, input logic [31:0] e_redir,
    input logic [31:0] e_pcf, input logic [31:0] e_pmis);
    vec_t v;
    v.rst = r;  v.pc = pc;  v.uv = uv;  v.upc = upc;  v.cf = cf;  v.jmp = jmp;
    v.tk = tk;  v.tgt = tgt;  v.ptk = ptk;  v.ptgt = ptgt;
    v.e_hit = e_hit;  v.e_tk = e_tk;  v.e_next = e_next;  v.e_mis = e_mis;
    v.e_redir = e_redir;  v.e_pcf = e_pcf;  v.e_pmis = e_pmis;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  // Drive one cycle's inputs just after the edge, compare on the falling edge.
  task automatic step(input vec_t v, input int row);
    vec_t e;
    rst             = v.rst;
    pred_pc         = v.pc;
    upd_valid       = v.uv;
    upd_pc          = v.upc;
    upd_is_cf       = v.cf;
    upd_is_jump     = v.jmp;
    upd_taken       = v.tk;
    upd_target      = v.tgt;
    upd_pred_taken  = v.ptk;
    upd_pred_target = v.ptgt;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk("pred_hit",     row, {31'b0, pred_hit},       {31'b0, e.e_hit});
    chk("pred_taken",   row, {31'b0, pred_taken},     {31'b0, e.e_tk});
    chk("pred_next_pc", row, pred_next_pc,            e.e_next);
    chk("mispredict",   row, {31'b0, upd_mispredict}, {31'b0, e.e_mis});
    chk("redirect_pc",  row, upd_redirect_pc,         e.e_redir);
    chk("perf_cf",      row, perf_cf_count,           e.e_pcf);
    chk("perf_mis",     row, perf_mispredict_count,   e.e_pmis);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cold start, allocate, counter saturation both ways, gating on upd_valid.
    tbl.push_back(mk(0,'h40, 0,'h0 ,0,0,0,'h0  ,0,'h0  , 0,0,'h44 ,0,'h4  , 0,0));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,1,'h10 ,0,'h44 , 0,0,'h44 ,1,'h10 , 0,0));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,1,'h10 ,1,'h10 , 1,1,'h10 ,0,'h10 , 1,1));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,1,'h10 ,1,'h10 , 1,1,'h10 ,0,'h10 , 2,1));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,1,'h10 ,1,'h10 , 1,1,'h10 ,0,'h10 , 3,1));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,0,'h10 ,1,'h10 , 1,1,'h10 ,1,'h44 , 4,1));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,0,'h10 ,1,'h10 , 1,1,'h10 ,1,'h44 , 5,2));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,0,'h10 ,0,'h44 , 1,0,'h44 ,0,'h44 , 6,3));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,0,'h10 ,0,'h44 , 1,0,'h44 ,0,'h44 , 7,3));
    tbl.push_back(mk(0,'h40, 0,'h40,1,0,1,'h10 ,0,'h44 , 1,0,'h44 ,0,'h10 , 8,3));
    tbl.push_back(mk(0,'h40, 1,'h40,1,0,1,'h10 ,0,'h44 , 1,0,'h44 ,1,'h10 , 8,3));
    tbl.push_back(mk(0,'h40, 0,'h0 ,0,0,0,'h0  ,0,'h0  , 1,0,'h44 ,0,'h4  , 9,4));
    // Aliasing at index 0, stale-entry removal, not-taken miss, target mismatch, wrap.
    tbl.push_back(mk(0,'h80, 1,'h80,1,0,1,'h200,0,'h84 , 0,0,'h84 ,1,'h200, 9,4));
    tbl.push_back(mk(0,'h80, 0,'h0 ,0,0,0,'h0  ,0,'h0  , 1,1,'h200,0,'h4  ,10,5));
    tbl.push_back(mk(0,'h40, 0,'h0 ,0,0,0,'h0  ,0,'h0  , 0,0,'h44 ,0,'h4  ,10,5));
    tbl.push_back(mk(0,'h80, 1,'h80,0,0,0,'h0  ,1,'h200, 1,1,'h200,1,'h84 ,10,5));
    tbl.push_back(mk(0,'h80, 0,'h0 ,0,0,0,'h0  ,0,'h0  , 0,0,'h84 ,0,'h4  ,10,6));
    tbl.push_back(mk(0,'h84, 1,'h84,1,0,0,'h0  ,0,'h88 , 0,0,'h88 ,0,'h88 ,10,6));
    tbl.push_back(mk(0,'h84, 0,'h0 ,0,0,0,'h0  ,0,'h0  , 0,0,'h88 ,0,'h4  ,11,6));
    tbl.push_back(mk(0,'h84, 1,'h84,1,0,1,'h500,1,'h600, 0,0,'h88 ,1,'h500,11,6));
    tbl.push_back(mk(0,'h84, 0,'h0 ,0,0,0,'h0  ,0,'h0  , 1,1,'h500,0,'h4  ,12,7));
    tbl.push_back(mk(0,'hFFFF_FFFC, 0,'h0,0,0,0,'h0,0,'h0, 0,0,'h0 ,0,'h4  ,12,7));

    rst = 1'b1;  pred_pc = '0;  upd_valid = 1'b0;  upd_pc = '0;  upd_is_cf = 1'b0;
    upd_is_jump = 1'b0;  upd_taken = 1'b0;  upd_target = '0;
    upd_pred_taken = 1'b0;  upd_pred_target = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Jump collides with a same-cycle lookup, then jump bit overrides a drained counter.
    step(mk(0,'h100, 1,'h100,1,1,1,'h300,0,'h104, 0,0,'h104,1,'h300,12,7), 100);
    step(mk(0,'h100, 1,'h100,1,1,0,'h300,1,'h300, 1,1,'h300,1,'h104,13,8), 101);
    step(mk(0,'h100, 1,'h100,1,1,0,'h300,1,'h300, 1,1,'h300,1,'h104,14,9), 102);
    step(mk(0,'h100, 0,'h0  ,0,0,0,'h0  ,0,'h0  , 1,1,'h300,0,'h4  ,15,10), 103);
    // Mid-stream reset with a live update: the update must be dropped.
    step(mk(1,'h100, 1,'h140,1,0,1,'h700,0,'h144, 1,1,'h300,1,'h700,15,10), 104);
    step(mk(0,'h140, 0,'h0  ,0,0,0,'h0  ,0,'h0  , 0,0,'h144,0,'h4  , 0,0), 105);
    step(mk(0,'h100, 0,'h0  ,0,0,0,'h0  ,0,'h0  , 0,0,'h104,0,'h4  , 0,0), 106);

    chk("scoreboard_drain", 999, sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
